manchester_decoder: RTL and testbench



---
 rtl/manchester_pkg.sv | 20 ++
 rtl/manchester_half_timer.sv | 35 +++
 rtl/manchester_decoder.sv | 155 +++++++++++++++
 tb/tb_manchester_decoder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/manchester_pkg.sv
// Shared definitions for the Manchester encoder/decoder pair.
package manchester_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2,
    DONE   = 2'd3
  } man_state_t;

  // Line level during the first half of a '1' bit; the encoder uses the same
  // constant so both ends agree on polarity.
  localparam logic MAN_ONE_FIRST_HALF = 1'b0;

  // Cycle index inside a half-bit at which the line is sampled.
  function automatic int sample_idx(input int half);
    return half / 2;
  endfunction

endpackage

// File: rtl/manchester_half_timer.sv
// Half-bit timer: counts 0..HALF-1, flags the mid-half sample point and the
// last cycle of each half. Held at zero while restart is high.
module manchester_half_timer
  import manchester_pkg::*;
#(
  parameter int HALF = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic sample_pulse,
  output logic end_pulse
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] SAMPLE_AT = CW'(sample_idx(HALF));
  localparam logic [CW-1:0] END_AT    = CW'(HALF - 1);

  logic [CW-1:0] half_cnt;

  assign sample_pulse = (half_cnt == SAMPLE_AT);
  assign end_pulse    = (half_cnt == END_AT);

  // Half-bit counter; wraps to zero at the end of each half.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt <= '0;
    end else if (restart || end_pulse) begin
      half_cnt <= '0;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/manchester_decoder.sv
// Manchester (IEEE 802.3 polarity) frame decoder. A frame starts on the cycle
// after sync, each bit is two HALF-cycle halves sampled at their midpoint.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   IDLE   | waiting for sync
//   FIRST  | timing first half of a bit, captures s1 at mid-half
//   SECOND | timing second half, shifts in the bit and checks s1 != s2
//   DONE   | one cycle: data_valid high, data_out/code_err presented
module manchester_decoder
  import manchester_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int HALF   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sync,
  input  logic              din,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              code_err
);

  localparam int BW = $clog2(DATA_W) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  man_state_t        state_q, state_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              s1_q, s1_d;
  logic [DATA_W-1:0] shift_q, shift_d, shift_in;
  logic              err_q, err_d;
  logic              load_out;
  logic              timer_restart;
  logic              sample_pulse;
  logic              end_pulse;
  logic              dec_bit;

  // The decoded bit is the second-half level, expressed against the shared polarity.
  assign dec_bit = din ^ MAN_ONE_FIRST_HALF;

  if (DATA_W == 1) begin : g_shift_1
    assign shift_in = dec_bit;
  end else begin : g_shift_n
    assign shift_in = {shift_q[DATA_W-2:0], dec_bit};
  end

  // Timer is held at zero outside a frame and on any sync, so a frame (or a
  // restarted frame) always begins at half_cnt 0.
  assign timer_restart = (state_q == IDLE) || (state_q == DONE) || sync;

  manchester_half_timer #(
    .HALF (HALF)
  ) u_half_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .restart      (timer_restart),
    .sample_pulse (sample_pulse),
    .end_pulse    (end_pulse)
  );

  // Next-state, datapath next values and the valid strobe.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    s1_d       = s1_q;
    shift_d    = shift_q;
    err_d      = err_q;
    load_out   = 1'b0;
    data_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync) begin
          state_d   = FIRST;
          bit_cnt_d = '0;
          err_d     = 1'b0;
          shift_d   = '0;
        end
      end
      FIRST: begin
        if (sync) begin
          state_d   = FIRST;
          bit_cnt_d = '0;
          err_d     = 1'b0;
          shift_d   = '0;
        end else begin
          if (sample_pulse) s1_d = din;
          if (end_pulse) state_d = SECOND;
        end
      end
      SECOND: begin
        if (sync) begin
          state_d   = FIRST;
          bit_cnt_d = '0;
          err_d     = 1'b0;
          shift_d   = '0;
        end else begin
          if (sample_pulse) begin
            shift_d = shift_in;
            err_d   = err_q | (s1_q == din);
          end
          if (end_pulse) begin
            if (bit_cnt_q == LAST_BIT) begin
              state_d  = DONE;
              load_out = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              state_d   = FIRST;
            end
          end
        end
      end
      DONE: begin
        data_valid = 1'b1;
        if (sync) begin
          state_d   = FIRST;
          bit_cnt_d = '0;
          err_d     = 1'b0;
          shift_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; outputs load as the frame ends so they are
  // already valid during the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      s1_q      <= 1'b0;
      shift_q   <= '0;
      err_q     <= 1'b0;
      data_out  <= '0;
      code_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      s1_q      <= s1_d;
      shift_q   <= shift_d;
      err_q     <= err_d;
      if (load_out) begin
        data_out <= shift_d;
        code_err <= err_d;
      end
    end
  end

  assign busy = (state_q == FIRST) || (state_q == SECOND);

endmodule

// File: tb/tb_manchester_decoder.sv
// Bench for manchester_decoder: table of frames plus hand-written abort,
// back-to-back and mid-frame reset sequences, checked through a scoreboard.
module tb_manchester_decoder;

  localparam int DATA_W  = 8;
  localparam int HALF    = 4;
  localparam int FRAME_C = 2 * HALF * DATA_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sync = 1'b0;
  logic              din = 1'b0;
  logic              busy;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              code_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    int                cyc;
    logic [DATA_W-1:0] data;
    logic              err;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [DATA_W-1:0] word;
    int                viol;
    logic [DATA_W-1:0] exp_data;
    logic              exp_err;
  } vec_t;
  vec_t vecs[6];

  manchester_decoder #(
    .DATA_W (DATA_W),
    .HALF   (HALF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sync       (sync),
    .din        (din),
    .busy       (busy),
    .data_out   (data_out),
    .data_valid (data_valid),
    .code_err   (code_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock cycle with the given inputs; outputs are observed mid-cycle.
  task automatic tick(input logic s, input logic d);
    exp_t e;
    @(posedge clk);
    #1;
    sync = s;
    din  = d;
    cyc++;
    @(negedge clk);
    if (data_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'(data_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("valid_cycle", 32'(cyc), 32'(e.cyc));
        check("data_out", 32'(data_out), 32'(e.data));
        check("code_err", 32'(code_err), 32'(e.err));
        check("busy_in_done", 32'(busy), 32'd0);
      end
    end else if (exp_q.size() > 0 && cyc >= exp_q[0].cyc) begin
      e = exp_q.pop_front();
      check("missed_valid", 32'(data_valid), 32'd1);
    end
  endtask

  // Sync cycle followed by ncyc cycles of encoded data. Bit position viol
  // (LSB numbering, -1 for none) is held high for both halves.
  task automatic send_frame(input logic [DATA_W-1:0] w, input int viol, input int ncyc,
                            input bit expect_it, input logic [DATA_W-1:0] exp_data,
                            input logic exp_err);
    exp_t e;
    int   busy_low;
    tick(1'b1, 1'b0);
    if (expect_it) begin
      e.cyc  = cyc + FRAME_C + 1;
      e.data = exp_data;
      e.err  = exp_err;
      exp_q.push_back(e);
    end
    busy_low = 0;
    for (int t = 0; t < ncyc; t++) begin
      int   pos;
      logic b;
      logic d;
      pos = DATA_W - 1 - t / (2 * HALF);
      b   = w[pos];
      d   = (((t / HALF) % 2) == 1) ? b : ~b;
      if (pos == viol) d = 1'b1;
      tick(1'b0, d);
      if (!busy) busy_low++;
    end
    if (ncyc > 0) check("busy_during_frame", 32'(busy_low), 32'd0);
  endtask

  initial begin
    int busy_hi;
    int valid_hi;

    vecs[0] = '{8'hA5, -1, 8'hA5, 1'b0};
    vecs[1] = '{8'h3C,  4, 8'h3C, 1'b1};
    vecs[2] = '{8'h00, -1, 8'h00, 1'b0};
    vecs[3] = '{8'h5A,  0, 8'h5B, 1'b1};
    vecs[4] = '{8'hC3,  7, 8'hC3, 1'b1};
    vecs[5] = '{8'hFF, -1, 8'hFF, 1'b0};

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(data_valid), 32'd0);
    check("reset_data", 32'(data_out), 32'd0);
    check("reset_err", 32'(code_err), 32'd0);
    rst_n = 1'b1;
    busy_hi = 0;
    valid_hi = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1'b0, 1'b0);
      if (busy) busy_hi++;
      if (data_valid) valid_hi++;
    end
    check("idle_busy", 32'(busy_hi), 32'd0);
    check("idle_valid", 32'(valid_hi), 32'd0);
    check("idle_data", 32'(data_out), 32'd0);

    // Table-driven frames, each from idle
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].word, vecs[i].viol, FRAME_C, 1'b1, vecs[i].exp_data, vecs[i].exp_err);
      repeat (3) tick(1'b0, 1'b0);
      check("hold_data", 32'(data_out), 32'(vecs[i].exp_data));
      check("hold_err", 32'(code_err), 32'(vecs[i].exp_err));
    end

    // Abort: 0xFF cut short by a new sync, then 0x12 completes
    send_frame(8'hFF, -1, 29, 1'b0, 8'h00, 1'b0);
    check("abort_data_kept", 32'(data_out), 32'hFF);
    send_frame(8'h12, -1, FRAME_C, 1'b1, 8'h12, 1'b0);
    repeat (3) tick(1'b0, 1'b0);
    check("abort_result", 32'(data_out), 32'h12);

    // Back-to-back: sync lands in the DONE cycle of 0x81
    send_frame(8'h81, -1, FRAME_C, 1'b1, 8'h81, 1'b0);
    send_frame(8'h7E, -1, FRAME_C, 1'b1, 8'h7E, 1'b0);
    repeat (3) tick(1'b0, 1'b0);
    check("b2b_result", 32'(data_out), 32'h7E);

    // Reset mid-frame
    send_frame(8'h55, -1, 19, 1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(data_valid), 32'd0);
    check("midrst_data", 32'(data_out), 32'd0);
    check("midrst_err", 32'(code_err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(8'h55, -1, FRAME_C, 1'b1, 8'h55, 1'b0);
    repeat (3) tick(1'b0, 1'b0);
    check("postrst_data", 32'(data_out), 32'h55);

    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
